// File: rtl/reorder_buffer_mc.sv
// reorder_buffer_mc: in-order reorder buffer with NUM_CPL completion ports, single-commit head and flush on exception.
// Optional ROB_PERF_CNT_EN adds commit and full-stall counters.
module reorder_buffer_mc #(
  parameter int ROB_SIZE = 10,
  parameter int NUM_CPL = 2,
  parameter int XLEN = 32,
  localparam int IDX_W = $clog2(ROB_SIZE)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_allocate,
  input  logic [XLEN-1:0]          in_PC,
  input  logic [XLEN-1:0]          in_addr_miss,
  input  logic [4:0]               in_rd,
  input  logic [2:0]               in_instr_type,
  input  logic [NUM_CPL-1:0]       in_cpl_valid,
  input  logic [NUM_CPL*IDX_W-1:0] in_cpl_idx,
  input  logic [NUM_CPL*XLEN-1:0]  in_cpl_value,
  input  logic [NUM_CPL*3-1:0]     in_cpl_exception,
  input  logic                     in_stall,
  output logic                     out_ready,
  output logic [XLEN-1:0]          out_value,
  output logic [XLEN-1:0]          out_miss_addr,
  output logic [XLEN-1:0]          out_PC,
  output logic [4:0]               out_rd,
  output logic [2:0]               out_exception,
  output logic [2:0]               out_instr_type,
  output logic                     out_full,
  output logic                     out_empty,
  output logic [IDX_W-1:0]         out_alloc_idx,
  output logic [IDX_W:0]           out_count,
  output logic                     out_flush
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]              out_commit_cnt,
  output logic [31:0]              out_full_stall_cnt
`endif
);
  logic             valid_q    [ROB_SIZE];
  logic             complete_q [ROB_SIZE];
  logic [XLEN-1:0]  pc_q       [ROB_SIZE];
  logic [XLEN-1:0]  addr_q     [ROB_SIZE];
  logic [XLEN-1:0]  value_q    [ROB_SIZE];
  logic [4:0]       rd_q       [ROB_SIZE];
  logic [2:0]       type_q     [ROB_SIZE];
  logic [2:0]       exc_q      [ROB_SIZE];
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             flush_q;
  logic             alloc_fire, commit_fire, flush_fire;
  logic             cpl_hit [ROB_SIZE];
  logic [XLEN-1:0]  cpl_val [ROB_SIZE];
  logic [2:0]       cpl_exc [ROB_SIZE];

  assign out_ready      = valid_q[head_q] && complete_q[head_q];
  assign out_value      = value_q[head_q];
  assign out_miss_addr  = addr_q[head_q];
  assign out_PC         = pc_q[head_q];
  assign out_rd         = rd_q[head_q];
  assign out_exception  = exc_q[head_q];
  assign out_instr_type = type_q[head_q];
  assign out_full       = count_q == (IDX_W+1)'(ROB_SIZE);
  assign out_empty      = count_q == '0;
  assign out_alloc_idx  = tail_q;
  assign out_count      = count_q;
  assign out_flush      = flush_q;

  assign alloc_fire  = in_allocate && !out_full;
  assign commit_fire = out_ready && !in_stall;
  assign flush_fire  = commit_fire && out_exception != 3'b000;

  // Ports scanned high to low so the lowest-numbered hit is the one kept.
  always_comb begin
    for (int i = 0; i < ROB_SIZE; i++) begin
      cpl_hit[i] = 1'b0;
      cpl_val[i] = '0;
      cpl_exc[i] = '0;
      for (int p = NUM_CPL-1; p >= 0; p--)
        if (in_cpl_valid[p] && in_cpl_idx[p*IDX_W +: IDX_W] == IDX_W'(i)) begin
          cpl_hit[i] = 1'b1;
          cpl_val[i] = in_cpl_value[p*XLEN +: XLEN];
          cpl_exc[i] = in_cpl_exception[p*3 +: 3];
        end
    end
  end

  always_comb begin
    head_d  = !commit_fire ? head_q : head_q == IDX_W'(ROB_SIZE-1) ? '0 : head_q + 1'b1;
    tail_d  = !alloc_fire ? tail_q : tail_q == IDX_W'(ROB_SIZE-1) ? '0 : tail_q + 1'b1;
    count_d = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);
    if (flush_fire) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      flush_q <= 1'b0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        valid_q[i]    <= 1'b0;
        complete_q[i] <= 1'b0;
        pc_q[i]       <= '0;
        addr_q[i]     <= '0;
        value_q[i]    <= '0;
        rd_q[i]       <= '0;
        type_q[i]     <= '0;
        exc_q[i]      <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      flush_q <= flush_fire;
      if (flush_fire) begin
        for (int i = 0; i < ROB_SIZE; i++) begin
          valid_q[i]    <= 1'b0;
          complete_q[i] <= 1'b0;
        end
      end else begin
        for (int i = 0; i < ROB_SIZE; i++)
          if (cpl_hit[i] && valid_q[i]) begin
            complete_q[i] <= 1'b1;
            value_q[i]    <= cpl_val[i];
            exc_q[i]      <= cpl_exc[i];
          end
        if (alloc_fire) begin
          valid_q[tail_q]    <= 1'b1;
          complete_q[tail_q] <= 1'b0;
          pc_q[tail_q]       <= in_PC;
          addr_q[tail_q]     <= in_addr_miss;
          rd_q[tail_q]       <= in_rd;
          type_q[tail_q]     <= in_instr_type;
          value_q[tail_q]    <= '0;
          exc_q[tail_q]      <= '0;
        end
        if (commit_fire) begin
          valid_q[head_q]    <= 1'b0;
          complete_q[head_q] <= 1'b0;
        end
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] commit_cnt_q, full_stall_cnt_q;
  assign out_commit_cnt     = commit_cnt_q;
  assign out_full_stall_cnt = full_stall_cnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      commit_cnt_q     <= '0;
      full_stall_cnt_q <= '0;
    end else begin
      commit_cnt_q     <= flush_fire ? '0 : commit_cnt_q + 32'(commit_fire);
      full_stall_cnt_q <= flush_fire ? '0 : full_stall_cnt_q + 32'(in_allocate && out_full);
    end
  end
`endif
endmodule

// File: tb/tb_reorder_buffer_mc.sv
// tb_reorder_buffer_mc: directed self-checking bench for reorder_buffer_mc (ROB_SIZE=10, NUM_CPL=2).
module tb_reorder_buffer_mc;
  localparam int IDX_W = 4;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_allocate;
  logic [31:0] in_PC, in_addr_miss;
  logic [4:0]  in_rd;
  logic [2:0]  in_instr_type;
  logic [1:0]  in_cpl_valid;
  logic [7:0]  in_cpl_idx;
  logic [63:0] in_cpl_value;
  logic [5:0]  in_cpl_exception;
  logic        in_stall;
  logic        out_ready, out_full, out_empty, out_flush;
  logic [31:0] out_value, out_miss_addr, out_PC;
  logic [4:0]  out_rd;
  logic [2:0]  out_exception, out_instr_type;
  logic [3:0]  out_alloc_idx;
  logic [4:0]  out_count;
`ifdef ROB_PERF_CNT_EN
  logic [31:0] out_commit_cnt, out_full_stall_cnt;
`endif
  int n_tests = 0;
  int n_fail = 0;

  reorder_buffer_mc dut (
    .clk(clk), .reset(reset), .in_allocate(in_allocate), .in_PC(in_PC),
    .in_addr_miss(in_addr_miss), .in_rd(in_rd), .in_instr_type(in_instr_type),
    .in_cpl_valid(in_cpl_valid), .in_cpl_idx(in_cpl_idx), .in_cpl_value(in_cpl_value),
    .in_cpl_exception(in_cpl_exception), .in_stall(in_stall), .out_ready(out_ready),
    .out_value(out_value), .out_miss_addr(out_miss_addr), .out_PC(out_PC), .out_rd(out_rd),
    .out_exception(out_exception), .out_instr_type(out_instr_type), .out_full(out_full),
    .out_empty(out_empty), .out_alloc_idx(out_alloc_idx), .out_count(out_count),
    .out_flush(out_flush)
`ifdef ROB_PERF_CNT_EN
    , .out_commit_cnt(out_commit_cnt), .out_full_stall_cnt(out_full_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_allocate = 1'b0;
    in_PC = '0;
    in_addr_miss = '0;
    in_rd = '0;
    in_instr_type = '0;
    in_cpl_valid = '0;
    in_cpl_idx = '0;
    in_cpl_value = '0;
    in_cpl_exception = '0;
    in_stall = 1'b0;
  endtask

  task automatic alloc(input logic [31:0] pc, input logic [4:0] rd);
    in_allocate = 1'b1;
    in_PC = pc;
    in_addr_miss = pc + 32'h100;
    in_rd = rd;
    in_instr_type = 3'b001;
  endtask

  task automatic cpl(input int p, input logic [3:0] idx, input logic [31:0] v, input logic [2:0] e);
    in_cpl_valid[p] = 1'b1;
    in_cpl_idx[p*IDX_W +: IDX_W] = idx;
    in_cpl_value[p*32 +: 32] = v;
    in_cpl_exception[p*3 +: 3] = e;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #12;
    chk("rst_ready", out_ready, 0);
    chk("rst_empty", out_empty, 1);
    chk("rst_full", out_full, 0);
    chk("rst_alloc_idx", out_alloc_idx, 0);
    chk("rst_count", out_count, 0);
    chk("rst_value", out_value, 0);
    chk("rst_flush", out_flush, 0);
    reset = 1'b1;
    // single allocate / complete / commit
    in_allocate = 1'b1; in_PC = 32'h1000; in_rd = 5'd1; in_instr_type = 3'b000; in_addr_miss = 32'h55;
    tick();
    idle();
    chk("t1_alloc_idx", out_alloc_idx, 1);
    chk("t1_count", out_count, 1);
    chk("t1_ready0", out_ready, 0);
    cpl(0, 4'd0, 32'hDEADBEEF, 3'b000);
    tick();
    idle();
    chk("t1_ready1", out_ready, 1);
    chk("t1_value", out_value, 32'hDEADBEEF);
    chk("t1_rd", out_rd, 1);
    chk("t1_pc", out_PC, 32'h1000);
    chk("t1_miss", out_miss_addr, 32'h55);
    tick();
    chk("t1_empty", out_empty, 1);
    chk("t1_head_idx", out_alloc_idx, 1);
    // out-of-order completion on two ports, in-order commit
    alloc(32'h2000, 5'd2);
    tick();
    alloc(32'h2004, 5'd3);
    tick();
    idle();
    cpl(0, 4'd2, 32'hCAFEBABE, 3'b000);
    cpl(1, 4'd1, 32'h11111111, 3'b000);
    tick();
    idle();
    chk("t2_first", out_value, 32'h11111111);
    chk("t2_first_type", out_instr_type, 3'b001);
    tick();
    chk("t2_second", out_value, 32'hCAFEBABE);
    chk("t2_second_rd", out_rd, 3);
    tick();
    chk("t2_empty", out_empty, 1);
    // completion to the entry allocated in the same cycle is ignored
    alloc(32'h3000, 5'd4);
    cpl(0, 4'd3, 32'h99999999, 3'b000);
    tick();
    idle();
    chk("t3_same_cycle_ignored", out_ready, 0);
    in_stall = 1'b1;
    cpl(0, 4'd3, 32'hAAAA0000, 3'b000);
    cpl(1, 4'd3, 32'hBBBB0000, 3'b000);
    tick();
    idle();
    in_stall = 1'b1;
    chk("t3_port0_wins", out_value, 32'hAAAA0000);
    cpl(1, 4'd3, 32'h12345678, 3'b000);
    tick();
    idle();
    chk("t3_overwrite", out_value, 32'h12345678);
    chk("t3_count", out_count, 1);
    tick();
    chk("t3_empty", out_empty, 1);
    // out-of-range completion index ignored
    alloc(32'h4000, 5'd5);
    tick();
    idle();
    cpl(0, 4'd14, 32'h77777777, 3'b000);
    tick();
    idle();
    chk("t4_oob_ignored", out_ready, 0);
    cpl(0, 4'd4, 32'h5, 3'b000);
    tick();
    idle();
    tick();
    chk("t4_oob_drain", out_empty, 1);
    // fill to full from head=tail=5, check wrap, drop, and registered-full rule
    for (int i = 0; i < 5; i++) begin
      alloc(32'h5000 + 32'(i), 5'(i));
      tick();
    end
    chk("t4_wrap_idx", out_alloc_idx, 0);
    for (int i = 0; i < 5; i++) begin
      alloc(32'h6000 + 32'(i), 5'(i));
      tick();
    end
    chk("t4_full", out_full, 1);
    chk("t4_count10", out_count, 10);
    tick();
    idle();
    chk("t4_drop_count", out_count, 10);
    chk("t4_drop_idx", out_alloc_idx, 5);
    cpl(0, 4'd5, 32'h600D, 3'b000);
    tick();
    idle();
    alloc(32'h7000, 5'd9);
    tick();
    chk("t4_commit_no_alloc", out_count, 9);
    chk("t4_commit_idx", out_alloc_idx, 5);
    chk("t4_not_full", out_full, 0);
    tick();
    idle();
    chk("t4_refill_count", out_count, 10);
    chk("t4_refill_idx", out_alloc_idx, 6);
`ifdef ROB_PERF_CNT_EN
    chk("perf_commit", out_commit_cnt, 6);
    chk("perf_full_stall", out_full_stall_cnt, 2);
`endif
    // exception at head held by stall, then flush
    do_reset();
    chk("t5_reset_count", out_count, 0);
    alloc(32'h8000, 5'd7);
    tick();
    alloc(32'h8004, 5'd8);
    tick();
    idle();
    in_stall = 1'b1;
    cpl(0, 4'd0, 32'h7, 3'b001);
    tick();
    idle();
    in_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_stall_ready", out_ready, 1);
      chk("t5_stall_count", out_count, 2);
    end
    chk("t5_exc", out_exception, 3'b001);
    in_stall = 1'b0;
    alloc(32'h9000, 5'd9);
    tick();
    idle();
    chk("t5_flush", out_flush, 1);
    chk("t5_count", out_count, 0);
    chk("t5_empty", out_empty, 1);
    chk("t5_alloc_idx", out_alloc_idx, 0);
    chk("t5_ready", out_ready, 0);
    tick();
    chk("t5_flush_pulse", out_flush, 0);
    chk("t5_alloc_lost", out_count, 0);
    // asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) begin
      alloc(32'hA000 + 32'(i), 5'(i));
      tick();
    end
    idle();
    in_stall = 1'b1;
    cpl(0, 4'd0, 32'h1234, 3'b000);
    tick();
    chk("t6_pre_ready", out_ready, 1);
    chk("t6_pre_count", out_count, 5);
    reset = 1'b0;
    #1;
    chk("t6_async_count", out_count, 0);
    chk("t6_async_ready", out_ready, 0);
    chk("t6_async_empty", out_empty, 1);
    idle();
    #1;
    reset = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reorder_buffer_mc.md
Name: reorder_buffer_mc

Overview:
Parametrised successor to the single-port reorder buffer. It holds up to ROB_SIZE in-flight instructions in program order and accepts NUM_CPL completions per cycle (ALU, cache and other pipes). It retires at most one instruction per cycle from the head, under a stall handshake. A committed exception flushes the whole buffer. It sits between decode (allocation), the execute/cache writeback ports (completion) and the register-file commit stage.

Parameters:
ROB_SIZE, 10, number of entries; any value 2..32, power of two not required.
NUM_CPL, 2, number of independent completion ports.
XLEN, 32, data and PC width.
IDX_W, $clog2(ROB_SIZE), entry-index width; derived, not overridden.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low; 0 clears all state immediately.
in_allocate  in  1  allocation request from decode.
in_PC  in  XLEN  PC of the allocated instruction.
in_addr_miss  in  XLEN  faulting/miss address stored with the entry.
in_rd  in  5  destination register.
in_instr_type  in  3  instruction class (000 ALU, 001 load, 010 store, others opaque).
in_cpl_valid  in  NUM_CPL  per-port completion strobe.
in_cpl_idx  in  NUM_CPL*IDX_W  per-port entry index; port p uses bits [p*IDX_W +: IDX_W].
in_cpl_value  in  NUM_CPL*XLEN  per-port result.
in_cpl_exception  in  NUM_CPL*3  per-port exception code; 000 means none.
in_stall  in  1  commit stage cannot accept this cycle.
out_ready  out  1  head entry is valid and complete.
out_value  out  XLEN  head result.
out_miss_addr  out  XLEN  head addr_miss.
out_PC  out  XLEN  head PC.
out_rd  out  5  head rd.
out_exception  out  3  head exception code.
out_instr_type  out  3  head instruction type.
out_full  out  1  count == ROB_SIZE.
out_empty  out  1  count == 0.
out_alloc_idx  out  IDX_W  tail index; the index assigned to an allocation in this cycle.
out_count  out  IDX_W+1  current occupancy.
out_flush  out  1  registered pulse, the cycle after an excepting commit.

Behaviour:
- Reset (reset=0, asynchronous): head=tail=count=0; all valid/complete bits 0; out_flush=0. Then out_ready=0, out_full=0, out_empty=1, out_alloc_idx=0, out_count=0, and head data outputs are 0.
- Head outputs are combinational from head-entry state. No bypass: completion data written this cycle is visible at the earliest on the next cycle.
- Allocate fires when in_allocate && !out_full.
  - Writes PC, addr_miss, rd, instr_type at tail; valid=1, complete=0, value=0, exception=0.
  - tail advances, wrapping from ROB_SIZE-1 to 0 by explicit compare, not modulo 2^IDX_W.
  - in_allocate while full is dropped silently.
  - out_full uses the registered count, so a same-cycle commit does not permit allocation into a full buffer.
- Completion, per port p: if in_cpl_valid[p] and entry idx is valid, set complete=1 and write value and exception.
  - Completion to an invalid entry is ignored, including the entry being allocated in the same cycle.
  - Indices >= ROB_SIZE are ignored.
  - If two ports hit the same index, the lowest-numbered port wins.
  - Re-completing an already complete entry overwrites it (last writer wins).
- Commit fires when out_ready && !in_stall: clear valid and complete at head; head advances with the same wrap rule.
- count next = count + alloc_fire - commit_fire. Simultaneous allocate and commit leave count unchanged.
- Flush: a commit with out_exception != 000 clears every valid bit and sets head=tail=count=0 on the same edge.
  - Allocations and completions in that cycle are discarded.
  - out_flush=1 for exactly the next cycle.
- in_stall only blocks commit; allocation and completion proceed.
- Reset asserted mid-operation aborts everything immediately. No partial commit is visible.

Optional Feature:
ROB_PERF_CNT_EN: when defined, adds outputs out_commit_cnt (32b, committed instructions) and out_full_stall_cnt (32b, cycles with in_allocate && out_full). Both wrap at 2^32, clear on reset and clear on flush. Without the macro, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then allocate PC=1000 rd=1 type=000 -> out_alloc_idx goes 0 to 1, out_count=1, out_ready=0; complete port0 idx0 value DEADBEEF -> next cycle out_ready=1, out_value=DEADBEEF, out_rd=1; commit -> out_empty=1.
- Allocate 2 entries; same cycle port0 completes idx1=CAFEBABE and port1 completes idx0=11111111 -> head commits 11111111 then CAFEBABE in order.
- Both ports complete idx0 in the same cycle with values AAAA0000 and BBBB0000 -> out_value=AAAA0000 (port0 wins).
- Allocate 10 with ROB_SIZE=10 -> out_full=1; an 11th allocation is dropped and count stays 10; commit one, then allocate -> tail wraps to 0, out_alloc_idx=0.
- Head completes with exception 001 and in_stall=1 for 3 cycles -> no commit and out_ready stays 1; release stall -> next cycle out_flush=1, out_count=0, out_empty=1, and an allocation in the commit cycle is lost.
- Assert reset=0 asynchronously with 5 entries in flight -> out_count=0 and out_ready=0 before the next clock edge.
